eq_band_mixer: RTL
==================

// Module: eq_band_mixer
// PURPOSE
//   Parametrised N-band equaliser mixer. It is the successor to the fixed 3-band gain/sum stage.
//   - Accepts one sample per band from the band filters.
//   - Applies a per-band gain with a slew-limited ramp to avoid zipper noise.
//   - Accumulates the weighted bands through one time-multiplexed multiplier.
//   - Emits one saturated output sample to the DAC path.
// PARAMETERS
//   DATA_W     24  band/output sample width, signed two's complement
//   NUM_BANDS   3  number of bands, >= 1
//   GAIN_W      8  unsigned gain width, format Q2.(GAIN_W-2); unity = 1<<(GAIN_W-2)
//   RAMP_STEP   1  maximum LSB change of the applied gain per processed sample
// PORTS
//   clk          in   1                  system clock
//   reset_n      in   1                  asynchronous reset, active-low
//   in_valid     in   1                  band_data holds a valid sample set
//   in_ready     out  1                  mixer can accept a sample set
//   band_data    in   NUM_BANDS*DATA_W   band b occupies bits [b*DATA_W +: DATA_W]
//   gain_target  in   NUM_BANDS*GAIN_W   requested gain per band, same packing
//   out_valid    out  1                  one-cycle strobe; data_out is valid
//   data_out     out  DATA_W             saturated mixed sample
//   busy         out  1                  FSM is not in IDLE
//   clip_flag    out  1                  sticky clip indicator (EQ_MIX_CLIP_DETECT_EN only)
//   clip_clear   in   1                  clears clip_flag (EQ_MIX_CLIP_DETECT_EN only)
// BEHAVIOUR
//   Reset values: data_out=0, out_valid=0, busy=0, in_ready=1, acc=0, band index=0,
//     every applied gain = unity.
//   FSM states:
//   - IDLE: in_ready=1. When in_valid&in_ready, capture band_data into the band registers,
//     clear acc, set idx=0, go to MAC.
//   - MAC: one band per cycle.
//     - acc += band[idx] * gain_cur[idx]. Product is signed, DATA_W+GAIN_W+1 bits.
//     - acc width = DATA_W+GAIN_W+clog2(NUM_BANDS)+1, so no internal overflow is possible.
//     - In the same cycle, gain_cur[idx] moves toward gain_target[idx] by at most RAMP_STEP
//       and never overshoots. The new value applies to the next sample, not the current one.
//     - idx==NUM_BANDS-1 -> DONE; otherwise idx++.
//   - DONE: data_out <= sat(acc >>> (GAIN_W-2)) to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//     The shift is arithmetic. Pulse out_valid for one cycle, go to IDLE.
//   Timing:
//   - Latency: out_valid is asserted NUM_BANDS+1 cycles after the accepting edge.
//   - Throughput: one sample set per NUM_BANDS+2 cycles.
//   - in_ready=0 in MAC and DONE. in_valid asserted then is ignored and not queued.
//   - data_out holds its value between strobes.
//   gain_target handling:
//   - gain_target is sampled per band in that band's MAC cycle.
//   - A target change mid-sample affects only bands not yet processed.
//   - target==gain_cur: the gain is unchanged.
//   Boundary conditions:
//   - Full-scale negative input with maximum gain saturates to -2^(DATA_W-1).
//   - reset_n low at any time, including mid-MAC, aborts the sample immediately.
//     All state returns to its reset value and no out_valid is produced for the aborted sample.
// CONFIGURATION
//   Macro EQ_MIX_CLIP_DETECT_EN.
//   - Defined: clip_flag is set in DONE whenever saturation altered the value.
//     - clip_flag stays set until clip_clear is high at a clock edge.
//     - Set wins over a simultaneous clear.
//     - clip_flag resets to 0.
//   - Undefined: the clip_flag and clip_clear ports and the clip logic are absent;
//     datapath behaviour is identical.
// STRUCTURE
//   Package eq_pkg:
//   - mix_state_t enum {IDLE, MAC, DONE}.
//   - function unity_gain(GAIN_W).
//   - function sat_trunc() for generic saturation.
//   Sub-module eq_gain_ramp: one instance with a register array of NUM_BANDS gains,
//     indexed; it computes the slew-limited next gain from (cur, target, RAMP_STEP).
//   The mixer top holds the FSM, the band capture registers, the MAC and the output register.
// TESTING
//   1. All targets unity, bands {1000,-500,250} -> out_valid at +NUM_BANDS+1 cycles,
//      data_out=750.
//   2. Band0=2^23-1, gain target max, held for several samples -> the gain ramps 1 LSB per
//      sample, data_out saturates to 8388607, clip_flag=1 (macro defined).
//   3. Target changes unity->0 -> the applied gain descends by RAMP_STEP per sample and
//      settles at 0 exactly, with no overshoot. Output stays 0 once the gain reaches 0.
//   4. in_valid held high continuously -> acceptances are exactly NUM_BANDS+2 cycles apart,
//      and in_ready is low during MAC/DONE.
//   5. reset_n asserted in the 2nd MAC cycle -> all outputs go to reset values immediately,
//      and no out_valid follows. The next sample processes normally from unity gain.
//   6. NUM_BANDS=8, GAIN_W=10 build, all bands -2^23 at maximum gain -> data_out=-8388608,
//      with no accumulator wrap.

Source files
------------

// File: rtl/eq_band_mixer_pkg.sv
// Shared types and helpers for the N-band equaliser mixer.
package eq_pkg;

    // Mixer sequencing: capture, one MAC per band, then output.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } mix_state_t;

    // Working width for saturation; wide enough for every supported accumulator.
    localparam int SAT_W = 64;

    // Unity gain in Q2.(gain_w-2) format.
    function automatic int unsigned unity_gain(input int unsigned gain_w);
        return 32'd1 << (gain_w - 32'd2);
    endfunction

    // Clamp a signed value to the range of an out_w-bit two's complement number.
    function automatic logic signed [SAT_W-1:0] sat_trunc(input logic signed [SAT_W-1:0] v,
                                                          input int unsigned out_w);
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one = 1;
        hi  = (one <<< (out_w - 1)) - one;
        lo  = -hi - one;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/eq_band_mixer_if.sv
// Sample-set input handshake and mixed-sample output strobe of the band mixer.
interface eq_band_mixer_if #(
    parameter int DATA_W    = 24,
    parameter int NUM_BANDS = 3,
    parameter int GAIN_W    = 8
) ();
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_BANDS*DATA_W-1:0]   band_data;
    logic [NUM_BANDS*GAIN_W-1:0]   gain_target;
    logic                          out_valid;
    logic [DATA_W-1:0]             data_out;

    // Source of band samples / consumer of the mixed output.
    modport master (
        output in_valid, band_data, gain_target,
        input  in_ready, out_valid, data_out
    );

    // The mixer itself.
    modport slave (
        input  in_valid, band_data, gain_target,
        output in_ready, out_valid, data_out
    );
endinterface

// File: rtl/eq_band_mixer_gain_ramp.sv
// Per-band applied gains with slew-limited movement toward a target.
module eq_gain_ramp
    import eq_pkg::*;
#(
    parameter int GAIN_W    = 8,
    parameter int NUM_BANDS = 3,
    parameter int RAMP_STEP = 1,
    parameter int IDX_W     = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              upd_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [GAIN_W-1:0] target_i,
    output logic [GAIN_W-1:0] cur_o
);
    localparam int GMAX   = (1 << GAIN_W) - 1;
    localparam int STEP_C = (RAMP_STEP > GMAX) ? GMAX : RAMP_STEP;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_W));

    logic [GAIN_W-1:0] gain_q [NUM_BANDS];
    logic [GAIN_W-1:0] gain_d;
    logic [GAIN_W:0]   step;
    logic [GAIN_W:0]   diff;

    assign cur_o = gain_q[idx_i];

    // Move the selected gain toward its target by at most one step, never past it.
    always_comb begin
        step   = (GAIN_W+1)'(STEP_C);
        diff   = '0;
        gain_d = cur_o;
        if (target_i > cur_o) begin
            diff   = {1'b0, target_i} - {1'b0, cur_o};
            gain_d = (diff > step) ? (cur_o + step[GAIN_W-1:0]) : target_i;
        end else if (target_i < cur_o) begin
            diff   = {1'b0, cur_o} - {1'b0, target_i};
            gain_d = (diff > step) ? (cur_o - step[GAIN_W-1:0]) : target_i;
        end
    end

    // Gain register file; only the band being processed is updated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                gain_q[b] <= UNITY;
            end
        end else if (upd_i) begin
            gain_q[idx_i] <= gain_d;
        end
    end
endmodule

// File: rtl/eq_band_mixer.sv
// N-band equaliser mixer: captures a sample set, accumulates band*gain through one
// shared multiplier, and emits a saturated output sample.
// Optional sticky clip indicator: define EQ_MIX_CLIP_DETECT_EN.
module eq_band_mixer
    import eq_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int NUM_BANDS = 3,
    parameter int GAIN_W    = 8,
    parameter int RAMP_STEP = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    eq_band_mixer_if.slave  bus,
    output logic            busy
`ifdef EQ_MIX_CLIP_DETECT_EN
    ,
    output logic            clip_flag,
    input  logic            clip_clear
`endif
);
    localparam int IDX_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam int ACC_W  = DATA_W + GAIN_W + $clog2(NUM_BANDS) + 1;
    localparam int SHIFT  = GAIN_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);

    mix_state_t               state_q;
    logic [IDX_W-1:0]         idx_q;
    logic signed [DATA_W-1:0] band_q [NUM_BANDS];
    logic signed [ACC_W-1:0]  acc_q;
    logic [DATA_W-1:0]        data_out_q;
    logic                     out_valid_q;
    logic                     in_ready_q;
    logic                     busy_q;

    logic [GAIN_W-1:0]        gain_cur;
    logic [GAIN_W-1:0]        gain_tgt;
    logic signed [DATA_W-1:0] band_sel;
    logic signed [PROD_W-1:0] band_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [SAT_W-1:0]  acc_ext;
    logic signed [SAT_W-1:0]  shifted;
    logic signed [SAT_W-1:0]  sat_val;

    assign gain_tgt = bus.gain_target[int'(idx_q)*GAIN_W +: GAIN_W];

    eq_gain_ramp #(
        .GAIN_W    (GAIN_W),
        .NUM_BANDS (NUM_BANDS),
        .RAMP_STEP (RAMP_STEP),
        .IDX_W     (IDX_W)
    ) u_ramp (
        .clk      (clk),
        .reset_n  (reset_n),
        .upd_i    (state_q == MAC),
        .idx_i    (idx_q),
        .target_i (gain_tgt),
        .cur_o    (gain_cur)
    );

    // Shared multiplier, accumulator next value and output scaling/saturation.
    always_comb begin
        band_sel = band_q[idx_q];
        band_ext = PROD_W'(band_sel);
        gain_ext = PROD_W'($signed({1'b0, gain_cur}));
        prod     = band_ext * gain_ext;
        acc_d    = acc_q + ACC_W'(prod);
        acc_ext  = SAT_W'(acc_q);
        shifted  = acc_ext >>> SHIFT;
        sat_val  = sat_trunc(shifted, DATA_W);
    end

    // Control FSM with registered handshake/status outputs and the datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                band_q[b] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    if (bus.in_valid && in_ready_q) begin
                        for (int b = 0; b < NUM_BANDS; b++) begin
                            band_q[b] <= bus.band_data[b*DATA_W +: DATA_W];
                        end
                        acc_q      <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    data_out_q  <= sat_val[DATA_W-1:0];
                    out_valid_q <= 1'b1;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign busy          = busy_q;

`ifdef EQ_MIX_CLIP_DETECT_EN
    logic clip_q;

    // Sticky clip flag: set when saturation changed the output, set beats clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clip_q <= 1'b0;
        end else if ((state_q == DONE) && (sat_val != shifted)) begin
            clip_q <= 1'b1;
        end else if (clip_clear) begin
            clip_q <= 1'b0;
        end
    end

    assign clip_flag = clip_q;
`endif
endmodule
